// File: rtl/ps2_pkg.sv
// Shared constants, types and lookups for the PS/2 snake-direction path.
//   Scan codes    : extended/break prefixes, arrow and WASD make codes
//   Directions    : 2-bit encoding, 00 up, 01 right, 10 down, 11 left
//   dec_state_t   : decoder FSM states
//   dir_req_t     : result of a scan-code to direction lookup
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] dir;
    } dir_req_t;

    // WASD make codes (non-extended)
    function automatic dir_req_t wasd_lookup(input logic [7:0] code);
        dir_req_t r;
        r = '0;
        case (code)
            SC_W:    r = '{hit: 1'b1, dir: DIR_UP};
            SC_D:    r = '{hit: 1'b1, dir: DIR_RIGHT};
            SC_S:    r = '{hit: 1'b1, dir: DIR_DOWN};
            SC_A:    r = '{hit: 1'b1, dir: DIR_LEFT};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Arrow make codes (only valid after the E0 prefix)
    function automatic dir_req_t arrow_lookup(input logic [7:0] code);
        dir_req_t r;
        r = '0;
        case (code)
            SC_UP:    r = '{hit: 1'b1, dir: DIR_UP};
            SC_RIGHT: r = '{hit: 1'b1, dir: DIR_RIGHT};
            SC_DOWN:  r = '{hit: 1'b1, dir: DIR_DOWN};
            SC_LEFT:  r = '{hit: 1'b1, dir: DIR_LEFT};
            default:  r = '0;
        endcase
        return r;
    endfunction

    // A turn is legal only if it is neither a repeat nor a 180-degree reversal
    function automatic logic dir_ok(input logic [1:0] req, input logic [1:0] cur);
        return (req != cur) && (req != (cur ^ 2'b10));
    endfunction

endpackage

// File: rtl/ps2_direction_ctrl_if.sv
// Keyboard-side inputs and game-side outputs of the direction controller.
//   slave  : the controller (consumes ps2clk/ps2data, drives results)
//   master : the environment driving the keyboard lines
interface ps2_direction_ctrl_if;
    logic       ps2clk;
    logic       ps2data;
    logic [1:0] dir;
    logic       dir_valid;
    logic [7:0] keycode;
    logic       key_released;
    logic       frame_err;
    logic       idle;

    modport slave (
        input  ps2clk, ps2data,
        output dir, dir_valid, keycode, key_released, frame_err, idle
    );

    modport master (
        output ps2clk, ps2data,
        input  dir, dir_valid, keycode, key_released, frame_err, idle
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the keyboard lines, shifts in 11-bit
// frames on ps2clk falling edges, checks start/parity/stop, and discards
// stalled partial frames after TIMEOUT_CYCLES.
//   clk, reset        : system clock, synchronous active-high reset
//   ps2clk, ps2data   : raw asynchronous keyboard lines
//   data_byte         : last good data byte
//   byte_valid        : one-cycle strobe when data_byte is updated
//   frame_err         : one-cycle pulse on bad frame or timeout
//   idle              : no frame in progress
module ps2_frame_rx #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       idle
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall_q;
    logic                   data_q;
    logic [3:0]             bit_cnt;
    logic [10:0]            shreg;
    logic                   done;
    logic [TW-1:0]          tcnt;
    logic                   frame_ok;

    // Bit 0 start=0, bits 8:1 data, bit 9 odd parity, bit 10 stop=1
    assign frame_ok = ~shreg[0] & shreg[10] & (^shreg[9:1]);

    // Synchroniser and registered falling-edge detect; data_q stays aligned to fall_q
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
            fall_q    <= 1'b0;
            data_q    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            fall_q    <= clk_prev & ~clk_sync[SYNC_STAGES-1];
            data_q    <= data_sync[SYNC_STAGES-1];
        end
    end

    // Bit assembly, frame check and mid-frame timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= 4'd0;
            shreg      <= '0;
            done       <= 1'b0;
            tcnt       <= '0;
            data_byte  <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            idle       <= 1'b1;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (done) begin
                done    <= 1'b0;
                bit_cnt <= 4'd0;
                idle    <= 1'b1;
                tcnt    <= '0;
                if (frame_ok) begin
                    data_byte  <= shreg[8:1];
                    byte_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end else if (fall_q) begin
                shreg <= {data_q, shreg[10:1]};
                tcnt  <= '0;
                // Count holds at 10 on the 11th bit; done clears it next cycle
                if (bit_cnt == 4'd10) begin
                    done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    idle    <= 1'b0;
                end
            end else if (bit_cnt != 4'd0) begin
                if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    frame_err <= 1'b1;
                    bit_cnt   <= 4'd0;
                    idle      <= 1'b1;
                    tcnt      <= '0;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_direction_ctrl.sv
// PS/2 keyboard to snake-direction controller: frame receiver plus the
// prefix decoder and direction register.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : ps2clk/ps2data in; dir, dir_valid, keycode, key_released,
//                frame_err, idle out
module ps2_direction_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_direction_ctrl_if.slave   bus
);
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       rx_idle;

    dec_state_t state;
    logic [1:0] dir_q;
    logic       dir_valid_q;
    logic       key_released_q;
    dir_req_t   req;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2clk     (bus.ps2clk),
        .ps2data    (bus.ps2data),
        .data_byte  (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_err),
        .idle       (rx_idle)
    );

    // Which lookup applies depends on whether the E0 prefix was seen
    always_comb begin
        req = '0;
        case (state)
            S_IDLE:  req = wasd_lookup(rx_byte);
            S_EXT:   req = arrow_lookup(rx_byte);
            default: req = '0;
        endcase
    end

    // Prefix decoder and direction register
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            dir_q          <= DIR_RIGHT;
            dir_valid_q    <= 1'b0;
            key_released_q <= 1'b0;
        end else begin
            dir_valid_q    <= 1'b0;
            key_released_q <= 1'b0;
            if (rx_err) begin
                state <= S_IDLE;
            end else if (rx_valid) begin
                if (req.hit && dir_ok(req.dir, dir_q)) begin
                    dir_q       <= req.dir;
                    dir_valid_q <= 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        if (rx_byte == SC_EXT)      state <= S_EXT;
                        else if (rx_byte == SC_BRK) state <= S_BRK;
                    end
                    S_EXT: begin
                        if (rx_byte == SC_BRK) state <= S_EXT_BRK;
                        else                   state <= S_IDLE;
                    end
                    S_BRK, S_EXT_BRK: begin
                        key_released_q <= 1'b1;
                        state          <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.dir          = dir_q;
    assign bus.dir_valid    = dir_valid_q;
    assign bus.key_released = key_released_q;
    assign bus.keycode      = rx_byte;
    assign bus.frame_err    = rx_err;
    assign bus.idle         = rx_idle;

endmodule

// File: tb/tb_ps2_direction_ctrl.sv
module tb_ps2_direction_ctrl;
    localparam int unsigned TB_TIMEOUT = 300;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_direction_ctrl_if bus();

    ps2_direction_ctrl #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Observed pulse counts
    int dv_cnt = 0, kr_cnt = 0, fe_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (bus.dir_valid)    dv_cnt++;
        if (bus.key_released) kr_cnt++;
        if (bus.frame_err)    fe_cnt++;
        if (bus.dir_valid && bus.key_released) both_cnt++;
    end

    // Reference model: prefix flags plus direction as a quarter-turn index
    logic [1:0] m_dir;
    logic [7:0] m_key;
    bit         m_ext, m_brk;
    int         m_dv, m_kr, m_fe;

    task automatic clear_counts();
        dv_cnt = 0; kr_cnt = 0; fe_cnt = 0; both_cnt = 0;
        m_dv = 0; m_kr = 0; m_fe = 0;
    endtask

    task automatic model_reset();
        m_dir = 2'b01; m_key = 8'h00; m_ext = 0; m_brk = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int r;
        r = -1;
        m_key = b;
        if (m_brk) begin
            m_kr++; m_brk = 0; m_ext = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0 && !m_ext) begin
            m_ext = 1;
        end else begin
            if (m_ext) begin
                if (b == 8'h75) r = 0; else if (b == 8'h74) r = 1;
                else if (b == 8'h72) r = 2; else if (b == 8'h6B) r = 3;
            end else begin
                if (b == 8'h1D) r = 0; else if (b == 8'h23) r = 1;
                else if (b == 8'h1B) r = 2; else if (b == 8'h1C) r = 3;
            end
            m_ext = 0;
            // Only a quarter turn (odd difference) changes heading
            if (r >= 0 && (((r - int'(m_dir) + 4) % 4) % 2) == 1) begin
                m_dir = 2'(r);
                m_dv++;
            end
        end
    endtask

    task automatic model_error();
        m_fe++; m_ext = 0; m_brk = 0;
    endtask

    // Drive the first nbits of a frame; bad flips the parity bit
    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] fr;
        int h;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        h = int'($urandom_range(6, 14));
        for (int i = 0; i < nbits; i++) begin
            bus.ps2data = fr[i];
            repeat (h) @(posedge clk);
            bus.ps2clk = 1'b0;
            repeat (h) @(posedge clk);
            bus.ps2clk = 1'b1;
        end
        repeat (12) @(posedge clk);
        bus.ps2data = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic xmit(input logic [7:0] b, input bit bad);
        send_frame(b, bad, 11);
        if (bad) model_error(); else model_byte(b);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        model_reset();
        clear_counts();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.dir !== 2'b01) begin errors++; $display("FAIL reset_dir got=%b exp=01", bus.dir); end
        checks++; if (bus.keycode !== 8'h00) begin errors++; $display("FAIL reset_keycode got=%h exp=00", bus.keycode); end
        checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", bus.idle); end
        checks++; if ({bus.dir_valid, bus.key_released, bus.frame_err} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got=%b exp=000", {bus.dir_valid, bus.key_released, bus.frame_err}); end
    endtask

    task automatic test_ext_arrow();
        xmit(8'hE0, 0); xmit(8'h75, 0);
        checks++; if (bus.dir !== 2'b00) begin errors++; $display("FAIL ext_dir got=%b exp=00", bus.dir); end
        checks++; if (dv_cnt !== 1) begin errors++; $display("FAIL ext_dv_count got=%0d exp=1", dv_cnt); end
        checks++; if (bus.keycode !== 8'h75) begin errors++; $display("FAIL ext_keycode got=%h exp=75", bus.keycode); end
        checks++; if (kr_cnt !== 0) begin errors++; $display("FAIL ext_kr_count got=%0d exp=0", kr_cnt); end
    endtask

    task automatic test_reversal();
        apply_reset();
        xmit(8'h1C, 0);
        checks++; if (bus.dir !== 2'b01 || dv_cnt !== 0) begin
            errors++; $display("FAIL reversal_drop got dir=%b dv=%0d exp dir=01 dv=0", bus.dir, dv_cnt); end
        xmit(8'h1D, 0);
        checks++; if (bus.dir !== 2'b00 || dv_cnt !== 1) begin
            errors++; $display("FAIL turn_up got dir=%b dv=%0d exp dir=00 dv=1", bus.dir, dv_cnt); end
    endtask

    task automatic test_break();
        clear_counts();
        xmit(8'hF0, 0); xmit(8'h1D, 0);
        checks++; if (kr_cnt !== 1 || bus.dir !== m_dir) begin
            errors++; $display("FAIL break got kr=%0d dir=%b exp kr=1 dir=%b", kr_cnt, bus.dir, m_dir); end
        xmit(8'hE0, 0); xmit(8'hF0, 0); xmit(8'h74, 0);
        checks++; if (kr_cnt !== 2 || dv_cnt !== 0) begin
            errors++; $display("FAIL ext_break got kr=%0d dv=%0d exp kr=2 dv=0", kr_cnt, dv_cnt); end
    endtask

    task automatic test_parity_err();
        apply_reset();
        xmit(8'h1B, 1);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL parity_err_count got=%0d exp=1", fe_cnt); end
        checks++; if (bus.keycode !== 8'h00 || bus.dir !== 2'b01) begin
            errors++; $display("FAIL parity_hold got key=%h dir=%b exp key=00 dir=01", bus.keycode, bus.dir); end
        xmit(8'h1B, 0);
        checks++; if (bus.dir !== 2'b10 || dv_cnt !== 1) begin
            errors++; $display("FAIL parity_recover got dir=%b dv=%0d exp dir=10 dv=1", bus.dir, dv_cnt); end
    endtask

    task automatic test_timeout();
        clear_counts();
        send_frame(8'h5A, 0, 5);
        checks++; if (bus.idle !== 1'b0) begin errors++; $display("FAIL timeout_busy got idle=%b exp=0", bus.idle); end
        repeat (TB_TIMEOUT + 10) @(posedge clk);
        @(negedge clk); #1;
        model_error();
        checks++; if (fe_cnt !== 1 || bus.idle !== 1'b1) begin
            errors++; $display("FAIL timeout got fe=%0d idle=%b exp fe=1 idle=1", fe_cnt, bus.idle); end
        xmit(8'h23, 0);
        checks++; if (bus.dir !== m_dir || bus.keycode !== 8'h23 || dv_cnt !== m_dv) begin
            errors++; $display("FAIL timeout_recover got dir=%b key=%h dv=%0d exp dir=%b key=23 dv=%0d",
                               bus.dir, bus.keycode, dv_cnt, m_dir, m_dv); end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h72, 0, 6);
        apply_reset();
        repeat (TB_TIMEOUT + 10) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (bus.dir !== 2'b01 || bus.keycode !== 8'h00 || bus.idle !== 1'b1) begin
            errors++; $display("FAIL midreset_state got dir=%b key=%h idle=%b exp 01 00 1", bus.dir, bus.keycode, bus.idle); end
        xmit(8'hE0, 0); xmit(8'h72, 0);
        checks++; if (bus.dir !== 2'b10 || dv_cnt !== 1 || fe_cnt !== 0) begin
            errors++; $display("FAIL midreset_decode got dir=%b dv=%0d fe=%0d exp dir=10 dv=1 fe=0", bus.dir, dv_cnt, fe_cnt); end
    endtask

    task automatic test_random();
        logic [7:0] pool [0:10];
        logic [7:0] b;
        bit bad;
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h75, 8'h74, 8'h72, 8'h6B, 8'h00};
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            b = pool[$urandom_range(0, 10)];
            if (b == 8'h00) b = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            xmit(b, bad);
            checks++; if (bus.dir !== m_dir || bus.keycode !== m_key || bus.idle !== 1'b1) begin
                errors++; $display("FAIL rand_state n=%0d byte=%h got dir=%b key=%h idle=%b exp dir=%b key=%h idle=1",
                                   n, b, bus.dir, bus.keycode, bus.idle, m_dir, m_key); end
            checks++; if (dv_cnt !== m_dv || kr_cnt !== m_kr || fe_cnt !== m_fe || both_cnt !== 0) begin
                errors++; $display("FAIL rand_pulses n=%0d got dv=%0d kr=%0d fe=%0d both=%0d exp dv=%0d kr=%0d fe=%0d both=0",
                                   n, dv_cnt, kr_cnt, fe_cnt, both_cnt, m_dv, m_kr, m_fe); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.ps2clk = 1'b1;
        bus.ps2data = 1'b1;
        model_reset();
        clear_counts();
        test_reset();
        test_ext_arrow();
        test_reversal();
        test_break();
        test_parity_err();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
